// File: rtl/alu_flag_pipe.sv
// alu_flag_pipe: two-stage valid/ready EX-stage ALU with Z/N/V/C flags.
// Stage 1 registers the W+1-bit adder result, and stage 2 turns it into a result and flags.
// Optional feature macro: STICKY_OVF_EN adds the sticky_v and clr_sticky ports
// and a sticky overflow register.
module alu_flag_pipe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic         sign,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_v,
  output logic         flag_c
`ifdef STICKY_OVF_EN
  ,
  output logic         sticky_v,
  input  logic         clr_sticky
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SEQ = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_SLE = 3'b100;
  localparam logic [2:0] OP_SCO = 3'b101;

  // Stage 1 state
  logic         r_s1_valid;
  logic [2:0]   r_s1_op;
  logic         r_s1_sign;
  logic         r_s1_a_msb;
  logic         r_s1_b_msb;
  logic [W:0]   r_s1_sum;

  // Stage 2 state
  logic         r_s2_valid;
  logic [W-1:0] r_result;
  logic         r_z;
  logic         r_n;
  logic         r_v;
  logic         r_c;

  logic         w_s1_adv;
  logic         w_s2_adv;
  logic         w_accept;
  logic         w_cin;
  logic [W-1:0] w_b_eff;
  logic [W:0]   w_sum;
  logic         w_s2_cin;
  logic         w_s2_beff_msb;
  logic         w_v;
  logic         w_c;
  logic         w_eq;
  logic         w_lt;
  logic [W-1:0] w_res;
  logic         w_res_v;
  logic         w_res_c;

  assign w_s2_adv = ~r_s2_valid | out_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign in_ready = w_s1_adv & ~flush;
  assign w_accept = in_valid & in_ready;

  // Stage-1 adder: subtract-style ops use a + ~b + 1.
  always_comb begin
    w_cin   = (op == OP_SUB) || (op == OP_SEQ) || (op == OP_SLT) || (op == OP_SLE);
    w_b_eff = w_cin ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, w_cin};
  end

  // Stage-1 valid and operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_a_msb <= 1'b0;
      r_s1_b_msb <= 1'b0;
      r_s1_sum   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_op    <= op;
        r_s1_sign  <= sign;
        r_s1_a_msb <= a[W-1];
        r_s1_b_msb <= b[W-1];
        r_s1_sum   <= w_sum;
      end
    end
  end

  // Stage-2 result and flag decode from the registered sum.
  always_comb begin
    w_s2_cin      = (r_s1_op == OP_SUB) || (r_s1_op == OP_SEQ) ||
                    (r_s1_op == OP_SLT) || (r_s1_op == OP_SLE);
    w_s2_beff_msb = w_s2_cin ? ~r_s1_b_msb : r_s1_b_msb;
    w_v           = (r_s1_a_msb == w_s2_beff_msb) && (r_s1_sum[W-1] != r_s1_a_msb);
    w_c           = r_s1_sum[W];
    w_eq          = (r_s1_sum[W-1:0] == '0);
    w_lt          = r_s1_sign ? (r_s1_sum[W-1] ^ w_v) : ~w_c;
    w_res         = r_s1_sum[W-1:0];
    w_res_v       = w_v;
    w_res_c       = w_c;
    case (r_s1_op)
      OP_SEQ: begin
        w_res   = {{(W-1){1'b0}}, w_eq};
        w_res_v = 1'b0;
        w_res_c = 1'b0;
      end
      OP_SLT: begin
        w_res   = {{(W-1){1'b0}}, w_lt};
        w_res_v = 1'b0;
        w_res_c = 1'b0;
      end
      OP_SLE: begin
        w_res   = {{(W-1){1'b0}}, w_lt | w_eq};
        w_res_v = 1'b0;
        w_res_c = 1'b0;
      end
      OP_SCO: begin
        w_res   = {{(W-1){1'b0}}, w_c};
        w_res_v = 1'b0;
        w_res_c = 1'b0;
      end
      default: ; // ADD, SUB and reserved (as ADD) keep the sum and the V/C flags
    endcase
  end

  // Stage-2 valid and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_z        <= 1'b0;
      r_n        <= 1'b0;
      r_v        <= 1'b0;
      r_c        <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_z      <= (w_res == '0);
        r_n      <= w_res[W-1];
        r_v      <= w_res_v;
        r_c      <= w_res_c;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;
  assign flag_c    = r_c;

`ifdef STICKY_OVF_EN
  logic r_sticky;

  // Sticky overflow: set on an overflowing output transfer; set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (r_s2_valid && out_ready && r_v) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign sticky_v = r_sticky;
`endif

endmodule
